// File: rtl/wishbone_multibank.sv
// wishbone_multibank: NPORTS pipelined Wishbone slave ports sharing NBANKS 32-bit SRAM banks.
// Latency: ack/err one cycle after acceptance; read data registered with ack (read-first on writes).
// Backpressure: a port that loses same-bank arbitration sees combinational stall; bad banks never stall.
// Build option: WBMB_FIXED_PRIO_EN selects fixed lowest-index-wins arbitration instead of round-robin.
module wishbone_multibank #(
  parameter int NPORTS  = 2,
  parameter int NBANKS  = 2,
  parameter int A_WIDTH = 8,
  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  localparam int AW = A_WIDTH + BW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS-1:0]    wb_stb_i,
  input  logic [NPORTS*AW-1:0] wb_addr_i,
  input  logic [NPORTS*4-1:0]  wb_we_i,
  input  logic [NPORTS*32-1:0] wb_data_i,
  output logic [NPORTS-1:0]    wb_ack_o,
  output logic [NPORTS-1:0]    wb_err_o,
  output logic [NPORTS-1:0]    wb_stall_o,
  output logic [NPORTS*32-1:0] wb_data_o
);

  localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int DEPTH = 2 ** A_WIDTH;

  logic [31:0]        mem [NBANKS][DEPTH];

  logic [BW-1:0]      portBank [NPORTS];
  logic [A_WIDTH-1:0] portWord [NPORTS];
  logic [NPORTS-1:0]  portInRange;
  logic [NPORTS-1:0]  portGnt;
  logic [NPORTS-1:0]  portErr;

  logic [NBANKS-1:0]  bankGntVld;
  logic [PW-1:0]      bankGntIdx [NBANKS];
  logic [A_WIDTH-1:0] bankWord   [NBANKS];
  logic [3:0]         bankWe     [NBANKS];
  logic [31:0]        bankWdat   [NBANKS];

  logic [NPORTS-1:0]    ackQ;
  logic [NPORTS-1:0]    errQ;
  logic [NPORTS*32-1:0] dataQ;

`ifndef WBMB_FIXED_PRIO_EN
  logic [PW-1:0]      rrPtr [NBANKS];
`endif

  // Split each port address into bank/word fields; out-of-range banks become error requests.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      portBank[p]    = wb_addr_i[p*AW+A_WIDTH +: BW];
      portWord[p]    = wb_addr_i[p*AW +: A_WIDTH];
      portInRange[p] = (int'(portBank[p]) < NBANKS);
      portErr[p]     = !rst && wb_stb_i[p] && !portInRange[p];
    end
  end

  // Per-bank arbitration: first requester scanning upward from the bank's start index, wrapping.
  always_comb begin
    int start;
    int idx;
    start   = 0;
    idx     = 0;
    portGnt = '0;
    for (int b = 0; b < NBANKS; b++) begin
      bankGntVld[b] = 1'b0;
      bankGntIdx[b] = '0;
      bankWord[b]   = '0;
      bankWe[b]     = '0;
      bankWdat[b]   = '0;
`ifdef WBMB_FIXED_PRIO_EN
      start = 0;
`else
      start = int'(rrPtr[b]);
`endif
      for (int k = 0; k < NPORTS; k++) begin
        idx = (start + k) % NPORTS;
        if (!bankGntVld[b] && !rst && wb_stb_i[idx] && portInRange[idx] &&
            (int'(portBank[idx]) == b)) begin
          bankGntVld[b] = 1'b1;
          bankGntIdx[b] = PW'(idx);
          bankWord[b]   = portWord[idx];
          bankWe[b]     = wb_we_i[idx*4 +: 4];
          bankWdat[b]   = wb_data_i[idx*32 +: 32];
        end
      end
      if (bankGntVld[b]) portGnt[bankGntIdx[b]] = 1'b1;
    end
  end

  // Losers of a valid bank stall; nothing stalls while in reset.
  assign wb_stall_o = wb_stb_i & portInRange & ~portGnt & {NPORTS{!rst}};

`ifndef WBMB_FIXED_PRIO_EN
  // Move a bank's pointer just past its winner on every grant; idle banks keep their pointer.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NBANKS; b++) begin
      if (rst) begin
        rrPtr[b] <= '0;
      end else if (bankGntVld[b]) begin
        rrPtr[b] <= (int'(bankGntIdx[b]) == NPORTS-1) ? '0 : bankGntIdx[b] + 1'b1;
      end
    end
  end
`endif

  // Byte-lane writes from each bank's winner; RAM contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NBANKS; b++) begin
      if (bankGntVld[b]) begin
        for (int i = 0; i < 4; i++) begin
          if (bankWe[b][i]) mem[b][bankWord[b]][i*8 +: 8] <= bankWdat[b][i*8 +: 8];
        end
      end
    end
  end

  // Completion flags and read data; the read samples the word before this edge's write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ackQ  <= '0;
      errQ  <= '0;
      dataQ <= '0;
    end else begin
      ackQ <= portGnt;
      errQ <= portErr;
      for (int p = 0; p < NPORTS; p++) begin
        if (portGnt[p]) dataQ[p*32 +: 32] <= mem[portBank[p]][portWord[p]];
      end
    end
  end

  // Reset suppresses completions of requests accepted just before it rose.
  assign wb_ack_o  = ackQ & {NPORTS{!rst}};
  assign wb_err_o  = errQ & {NPORTS{!rst}};
  assign wb_data_o = dataQ;

endmodule
